// File: rtl/demux_deser_pkg.sv
// Shared definitions for the serial-to-parallel demultiplexer.
package demux_deser_pkg;

    // Word assembly state: FILL collects bits, HOLD presents a finished word.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } demux_state_t;

endpackage : demux_deser_pkg

// File: rtl/demux_deser.sv
// Serial-to-parallel demultiplexer: gathers bits LSB first into an N-bit word,
// closing the word when full or when flushed, with valid/ready handshakes on
// both sides and zero-bubble handover between consecutive words.
module demux_deser
    import demux_deser_pkg::*;
#(
    parameter int N   = 4,
    parameter int SEL = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           demux_din,
    input  logic           demux_din_valid,
    output logic           demux_din_ready,
    input  logic           demux_flush,
    output logic [N-1:0]   demux_dout,
    output logic [SEL:0]   demux_dout_cnt,
    output logic           demux_dout_valid,
    input  logic           demux_dout_ready,
    output logic [SEL-1:0] demux_idx
);

    localparam logic [SEL-1:0] IDX_LAST = SEL'(N - 1);
    localparam logic [SEL-1:0] IDX_ONE  = SEL'(1);
    localparam logic [SEL-1:0] IDX_ZERO = '0;
    localparam logic [SEL:0]   CNT_FULL = (SEL + 1)'(N);
    localparam logic [SEL:0]   CNT_ONE  = (SEL + 1)'(1);

    demux_state_t   state_q;
    logic [N-1:0]   word_q;
    logic [SEL:0]   cnt_q;
    logic           valid_q;
    logic [SEL-1:0] idx_q;

    logic [N-1:0]   word_ins;
    logic           bit_xfer;
    logic           word_xfer;

    // Input is always open while filling; while holding, a bit may only enter
    // in the same cycle the held word leaves, so ready follows the consumer.
    assign demux_din_ready = (state_q == FILL) || demux_dout_ready;

    assign bit_xfer  = demux_din_valid && demux_din_ready;
    assign word_xfer = valid_q && demux_dout_ready;

    assign demux_dout       = word_q;
    assign demux_dout_cnt   = cnt_q;
    assign demux_dout_valid = valid_q;
    assign demux_idx        = idx_q;

    // Write decoder: current word with the incoming bit placed at idx_q.
    always_comb begin
        // NOTE: default assignment first so every path drives word_ins and no latch is inferred.
        word_ins = word_q;
        for (int i = 0; i < N; i++) begin
            if (idx_q == SEL'(i)) begin
                word_ins[i] = demux_din;
            end
        end
    end

    // Fill/hold state machine with registered word, count, valid and index.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= FILL;
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bit_xfer) begin
                        word_q <= word_ins;
                        if (idx_q == IDX_LAST) begin
                            // Last position written: word is complete.
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            cnt_q   <= CNT_FULL;
                            idx_q   <= IDX_ZERO;
                        end else if (demux_flush) begin
                            // Flush together with a bit: that bit is included.
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            cnt_q   <= {1'b0, idx_q} + CNT_ONE;
                            idx_q   <= IDX_ZERO;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else if (demux_flush && (idx_q != IDX_ZERO)) begin
                        // Flush of a partial word; upper positions are already zero.
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                        cnt_q   <= {1'b0, idx_q};
                        idx_q   <= IDX_ZERO;
                    end
                end

                HOLD: begin
                    if (word_xfer) begin
                        state_q <= FILL;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        if (bit_xfer) begin
                            // Zero-bubble handover: the new bit starts the next word.
                            word_q <= N'(demux_din);
                            idx_q  <= IDX_ONE;
                        end else begin
                            word_q <= '0;
                            idx_q  <= IDX_ZERO;
                        end
                    end
                end

                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule : demux_deser

// File: tb/tb_demux_deser.sv
// Directed self-checking testbench for demux_deser with N = 4.
module tb_demux_deser;

    localparam int N   = 4;
    localparam int SEL = 2;

    logic           clk;
    logic           rst_n;
    logic           demux_din;
    logic           demux_din_valid;
    logic           demux_din_ready;
    logic           demux_flush;
    logic [N-1:0]   demux_dout;
    logic [SEL:0]   demux_dout_cnt;
    logic           demux_dout_valid;
    logic           demux_dout_ready;
    logic [SEL-1:0] demux_idx;

    int n_checks = 0;
    int n_errors = 0;

    demux_deser #(.N(N), .SEL(SEL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .demux_din        (demux_din),
        .demux_din_valid  (demux_din_valid),
        .demux_din_ready  (demux_din_ready),
        .demux_flush      (demux_flush),
        .demux_dout       (demux_dout),
        .demux_dout_cnt   (demux_dout_cnt),
        .demux_dout_valid (demux_dout_valid),
        .demux_dout_ready (demux_dout_ready),
        .demux_idx        (demux_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bit (optionally with flush) for a single cycle.
    task automatic send_bit(input logic b, input logic f);
        demux_din       = b;
        demux_din_valid = 1'b1;
        demux_flush     = f;
        step();
        demux_din_valid = 1'b0;
        demux_flush     = 1'b0;
        demux_din       = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"},  32'(demux_dout), 32'h0);
        check({tag, "_cnt"},   32'(demux_dout_cnt), 32'h0);
        check({tag, "_valid"}, 32'(demux_dout_valid), 32'h0);
        check({tag, "_idx"},   32'(demux_idx), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] stream;
        logic [3:0]  exp_nib [4];
        int          words_seen;

        rst_n            = 1'b0;
        demux_din        = 1'b1;
        demux_din_valid  = 1'b1;
        demux_flush      = 1'b1;
        demux_dout_ready = 1'b1;

        // Reset with all inputs active must still clear everything.
        step();
        step();
        check_zero("reset");
        demux_din_valid = 1'b0;
        demux_flush     = 1'b0;
        demux_din       = 1'b0;
        rst_n           = 1'b1;
        step();
        check("ready_after_reset", 32'(demux_din_ready), 32'h1);
        check("idx_after_reset", 32'(demux_idx), 32'h0);

        // Bits 1,0,1,1 -> 4'b1101, valid for one cycle.
        send_bit(1'b1, 1'b0);
        check("b2b_idx1", 32'(demux_idx), 32'h1);
        send_bit(1'b0, 1'b0);
        check("b2b_idx2", 32'(demux_idx), 32'h2);
        // Idle cycles in FILL leave state unchanged.
        step();
        step();
        check("idle_idx", 32'(demux_idx), 32'h2);
        check("idle_valid", 32'(demux_dout_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        check("b2b_idx3", 32'(demux_idx), 32'h3);
        send_bit(1'b1, 1'b0);
        check("b2b_valid", 32'(demux_dout_valid), 32'h1);
        check("b2b_dout", 32'(demux_dout), 32'hD);
        check("b2b_cnt", 32'(demux_dout_cnt), 32'h4);
        check("b2b_idx_wrap", 32'(demux_idx), 32'h0);
        step();
        check("b2b_valid_drop", 32'(demux_dout_valid), 32'h0);
        check("b2b_cleared", 32'(demux_dout), 32'h0);

        // Two bits then flush -> 4'b0011, cnt 2.
        demux_dout_ready = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        demux_flush = 1'b1;
        step();
        demux_flush = 1'b0;
        check("flush_valid", 32'(demux_dout_valid), 32'h1);
        check("flush_dout", 32'(demux_dout), 32'h3);
        check("flush_cnt", 32'(demux_dout_cnt), 32'h2);
        check("flush_idx", 32'(demux_idx), 32'h0);
        // Flush while holding is ignored.
        demux_flush = 1'b1;
        step();
        demux_flush = 1'b0;
        check("flush_hold_cnt", 32'(demux_dout_cnt), 32'h2);
        demux_dout_ready = 1'b1;
        step();
        check("flush_taken", 32'(demux_dout_valid), 32'h0);
        // Flush with nothing held emits nothing.
        demux_flush = 1'b1;
        step();
        demux_flush = 1'b0;
        check("flush_empty_valid", 32'(demux_dout_valid), 32'h0);
        check("flush_empty_idx", 32'(demux_idx), 32'h0);
        // Flush in the same cycle as the first bit -> cnt 1.
        demux_dout_ready = 1'b0;
        send_bit(1'b1, 1'b1);
        check("flush_same_valid", 32'(demux_dout_valid), 32'h1);
        check("flush_same_dout", 32'(demux_dout), 32'h1);
        check("flush_same_cnt", 32'(demux_dout_cnt), 32'h1);
        demux_dout_ready = 1'b1;
        step();
        check("flush_same_taken", 32'(demux_dout_valid), 32'h0);

        // Backpressure in HOLD: no bit consumed, word stable.
        demux_dout_ready = 1'b0;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("bp_valid", 32'(demux_dout_valid), 32'h1);
        demux_din       = 1'b1;
        demux_din_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_ready_%0d", c), 32'(demux_din_ready), 32'h0);
            step();
            check($sformatf("bp_dout_%0d", c), 32'(demux_dout), 32'h6);
            check($sformatf("bp_cnt_%0d", c), 32'(demux_dout_cnt), 32'h4);
            check($sformatf("bp_idx_%0d", c), 32'(demux_idx), 32'h0);
        end
        demux_din_valid  = 1'b0;
        demux_din        = 1'b0;
        demux_dout_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(demux_din_ready), 32'h1);
        step();
        check("bp_release_valid", 32'(demux_dout_valid), 32'h0);
        check("bp_release_idx", 32'(demux_idx), 32'h0);
        check("bp_release_dout", 32'(demux_dout), 32'h0);

        // Continuous stream 0xA5C3 LSB first, zero bubbles.
        stream     = 16'hA5C3;
        exp_nib[0] = 4'h3;
        exp_nib[1] = 4'hC;
        exp_nib[2] = 4'h5;
        exp_nib[3] = 4'hA;
        words_seen = 0;
        demux_dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            demux_din       = stream[i];
            demux_din_valid = 1'b1;
            #1;
            check($sformatf("stream_ready_%0d", i), 32'(demux_din_ready), 32'h1);
            step();
            if ((i % 4) == 3) begin
                check($sformatf("stream_valid_%0d", i), 32'(demux_dout_valid), 32'h1);
                check($sformatf("stream_word_%0d", i / 4), 32'(demux_dout), 32'(exp_nib[i / 4]));
                check($sformatf("stream_cnt_%0d", i / 4), 32'(demux_dout_cnt), 32'h4);
            end else begin
                check($sformatf("stream_novalid_%0d", i), 32'(demux_dout_valid), 32'h0);
                check($sformatf("stream_idx_%0d", i), 32'(demux_idx), 32'((i % 4) + 1));
            end
            if (demux_dout_valid) words_seen++;
        end
        demux_din_valid = 1'b0;
        demux_din       = 1'b0;
        step();
        check("stream_words", 32'(words_seen), 32'h4);
        check("stream_end_valid", 32'(demux_dout_valid), 32'h0);

        // Reset mid-word discards the partial word.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        check_zero("rst_mid");
        rst_n = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("rst_mid_dout", 32'(demux_dout), 32'h8);
        check("rst_mid_cnt", 32'(demux_dout_cnt), 32'h4);
        check("rst_mid_valid", 32'(demux_dout_valid), 32'h1);

        // Reset while holding discards the held word.
        demux_dout_ready = 1'b0;
        step();
        check("rst_hold_pre", 32'(demux_dout_valid), 32'h1);
        rst_n = 1'b0;
        step();
        check_zero("rst_hold");
        rst_n = 1'b1;
        step();
        check("rst_hold_ready", 32'(demux_din_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_demux_deser
